// File: rtl/seven_seg_display_ctrl_if.sv
// Bundle between datapath logic and the multiplexed 7-segment display controller.
interface seven_seg_display_ctrl_if #(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned BRIGHT_BITS = 3
);
  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   blank;
  logic                    lz_suppress;
  logic [BRIGHT_BITS-1:0]  brightness;
  logic                    load;
  logic [NUM_DIGITS-1:0]   an;
  logic [6:0]              seg;
  logic                    dp;
  logic                    frame_done;

  // Datapath side: supplies values and strobes, watches the pins.
  modport master (
    output digits, dp_in, blank, lz_suppress, brightness, load,
    input  an, seg, dp, frame_done
  );

  // Controller side.
  modport slave (
    input  digits, dp_in, blank, lz_suppress, brightness, load,
    output an, seg, dp, frame_done
  );
endinterface

// File: rtl/seven_seg_display_ctrl.sv
// N-digit multiplexed 7-segment controller: prescaler, digit scan, double-buffered data,
// blanking, decimal points, leading-zero suppression and PWM brightness.
module seven_seg_display_ctrl #(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned DIVIDE_BY   = 17,
  parameter int unsigned BRIGHT_BITS = 3
) (
  input logic                     clock,
  input logic                     reset_n,
  seven_seg_display_ctrl_if.slave bus
);
  localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_DIGITS - 1);

  logic [DIVIDE_BY-1:0]    presc_q;
  logic [IdxW-1:0]         idx_q;
  logic                    tick, wrap;

  logic [4*NUM_DIGITS-1:0] sh_digits_q, act_digits_q;
  logic [NUM_DIGITS-1:0]   sh_dp_q, act_dp_q;
  logic [NUM_DIGITS-1:0]   sh_blank_q, act_blank_q;
  logic                    sh_lz_q, act_lz_q;
  logic                    pending_q;

  logic [NUM_DIGITS-1:0]   an_d, an_q;
  logic [6:0]              seg_d, seg_q;
  logic                    dp_d, dp_q;
  logic                    frame_done_q;

  logic [3:0]              cur_nib;
  logic                    cur_dp, cur_blank, upper_zero, pwm_off, dark;

  function automatic logic [6:0] decode(input logic [3:0] n);
    logic [6:0] s;
    unique case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
    endcase
    return s;
  endfunction

  assign tick = &presc_q;
  assign wrap = tick && (idx_q == LastIdx);

  // Free-running prescaler; digit index steps once per slot and wraps at the last digit.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      presc_q <= '0;
      idx_q   <= '0;
    end else begin
      presc_q <= presc_q + 1'b1;
      if (tick) idx_q <= wrap ? '0 : idx_q + 1'b1;
    end
  end

  // Shadow captures on load; active takes the old shadow only at a frame wrap, so a frame
  // never mixes old and new data. A load on the wrap edge keeps pending for the next frame.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sh_digits_q  <= '0;
      sh_dp_q      <= '0;
      sh_blank_q   <= '0;
      sh_lz_q      <= 1'b0;
      act_digits_q <= '0;
      act_dp_q     <= '0;
      act_blank_q  <= '1;
      act_lz_q     <= 1'b0;
      pending_q    <= 1'b0;
    end else begin
      if (wrap && pending_q) begin
        act_digits_q <= sh_digits_q;
        act_dp_q     <= sh_dp_q;
        act_blank_q  <= sh_blank_q;
        act_lz_q     <= sh_lz_q;
      end
      if (bus.load) begin
        sh_digits_q <= bus.digits;
        sh_dp_q     <= bus.dp_in;
        sh_blank_q  <= bus.blank;
        sh_lz_q     <= bus.lz_suppress;
        pending_q   <= 1'b1;
      end else if (wrap) begin
        pending_q   <= 1'b0;
      end
    end
  end

  // Select the current digit, decide whether the slot is dark, and form the pin values.
  always_comb begin
    cur_nib    = 4'h0;
    cur_dp     = 1'b0;
    cur_blank  = 1'b1;
    upper_zero = 1'b1;
    for (int k = 0; k < int'(NUM_DIGITS); k++) begin
      if (IdxW'(k) == idx_q) begin
        cur_nib   = act_digits_q[4*k +: 4];
        cur_dp    = act_dp_q[k];
        cur_blank = act_blank_q[k];
      end
      if (k >= int'(idx_q) && act_digits_q[4*k +: 4] != 4'h0) upper_zero = 1'b0;
    end
    pwm_off = presc_q[DIVIDE_BY-1 -: BRIGHT_BITS] > bus.brightness;
    dark    = cur_blank || (act_lz_q && (idx_q != '0) && upper_zero) || pwm_off;
    an_d    = '1;
    seg_d   = 7'h7F;
    dp_d    = 1'b1;
    if (!dark) begin
      an_d[idx_q] = 1'b0;
      seg_d       = decode(cur_nib);
      dp_d        = ~cur_dp;
    end
  end

  // Registered pins; frame_done marks the cycle after the wrap edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      an_q         <= '1;
      seg_q        <= 7'h7F;
      dp_q         <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_done_q <= wrap;
    end
  end

  assign bus.an         = an_q;
  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.frame_done = frame_done_q;

endmodule
